// File: rtl/bsg_gateway_link_traffic_checker_if.sv
// Ready/valid link channel pair between the traffic checker (master) and the
// CT/FIFO link block (slave): inbound packets out, looped-back packets in.
interface bsg_gateway_link_traffic_checker_if #(
  parameter int unsigned width_p = 64
);
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               ready_i;
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               yumi_o;

  modport master (
    output v_o, data_o, yumi_o,
    input  ready_i, v_i, data_i
  );

  modport slave (
    input  v_o, data_o, yumi_o,
    output ready_i, v_i, data_i
  );
endinterface

// File: rtl/bsg_gateway_link_traffic_checker.sv
// Link bring-up traffic generator/checker: sends an LFSR-tagged packet stream
// and checks the looped-back stream. Optional watchdog: BSG_GATEWAY_LINK_TIMEOUT_EN.
module bsg_gateway_link_traffic_checker #(
  parameter int unsigned width_p       = 64,
  parameter int unsigned num_packets_p = 256,
  parameter logic [31:0] seed_p        = 32'h1,
  parameter int unsigned timeout_p     = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  bsg_gateway_link_traffic_checker_if.master link,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] sent_count_o,
  output logic [15:0] recv_count_o,
`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
  output logic        timeout_o,
`endif
  output logic [15:0] error_count_o
);

  localparam int unsigned count_width_lp = 16;
  localparam int unsigned reps_lp        = (width_p - 16 + 31) / 32;
  localparam logic [count_width_lp-1:0] num_lp = count_width_lp'(num_packets_p);
  localparam logic [31:0] lfsr_taps_lp   = 32'h0040_0007;

  localparam logic [1:0] idle_s  = 2'd0;
  localparam logic [1:0] run_s   = 2'd1;
  localparam logic [1:0] drain_s = 2'd2;
  localparam logic [1:0] done_s  = 2'd3;

  // Reject illegal configurations at elaboration.
  if (width_p < 32 || num_packets_p == 0 || num_packets_p > 65535
      || seed_p == 32'h0 || timeout_p == 0) begin : g_param_check
    $error("bsg_gateway_link_traffic_checker: illegal parameter setting");
  end

  // Galois step for x^32+x^22+x^2+x+1 (multiply by x modulo the polynomial).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? lfsr_taps_lp : 32'h0);
  endfunction

  // Packet: sequence number in the low half-word, LFSR state replicated above.
  function automatic logic [width_p-1:0] make_pkt(input logic [15:0] seq,
                                                  input logic [31:0] s);
    logic [reps_lp*32-1:0] rep;
    rep = {reps_lp{s}};
    return {rep[width_p-17:0], seq};
  endfunction

  logic [1:0]                state_r, state_n;
  logic [31:0]               tx_lfsr_r, tx_lfsr_n;
  logic [31:0]               rx_lfsr_r, rx_lfsr_n;
  logic [count_width_lp-1:0] sent_r, sent_n;
  logic [count_width_lp-1:0] recv_r, recv_n;
  logic [count_width_lp-1:0] err_cnt_r, err_cnt_n;
  logic                      err_r, err_n;
  logic                      done_r, done_n;
  logic                      v_r, v_n;
  logic [width_p-1:0]        data_r, data_n;

  logic yumi_c, tx_fire, rx_check, rx_extra, rx_bad;
  logic tx_last, tx_done, rx_last, rx_done;

`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
  localparam int unsigned wd_width_lp = $clog2(timeout_p + 1);
  logic [wd_width_lp-1:0] wd_r, wd_n;
  logic                   timeout_r, timeout_n;
`endif

  // Receive side never back-pressures once a run has started.
  assign yumi_c      = link.v_i & (state_r != idle_s);
  assign link.yumi_o = yumi_c;
  assign link.v_o    = v_r;
  assign link.data_o = data_r;

  assign tx_fire  = v_r & link.ready_i;
  assign rx_check = yumi_c & ((state_r == run_s) | (state_r == drain_s));
  assign rx_extra = yumi_c & (state_r == done_s);
  assign rx_bad   = (rx_check & (link.data_i != make_pkt(recv_r, rx_lfsr_r))) | rx_extra;

  assign tx_last = tx_fire & (sent_r == num_lp - count_width_lp'(1));
  assign tx_done = tx_last | (sent_r >= num_lp);
  assign rx_last = rx_check & (recv_r == num_lp - count_width_lp'(1));
  assign rx_done = rx_last | (recv_r >= num_lp);

  // Next-state and datapath updates.
  always_comb begin
    state_n   = state_r;
    tx_lfsr_n = tx_lfsr_r;
    rx_lfsr_n = rx_lfsr_r;
    sent_n    = sent_r;
    recv_n    = recv_r;
    err_cnt_n = err_cnt_r;
    err_n     = err_r;
    data_n    = data_r;
`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
    wd_n      = '0;
    timeout_n = timeout_r;
`endif

    if (tx_fire) begin
      sent_n    = sent_r + count_width_lp'(1);
      tx_lfsr_n = lfsr_step(tx_lfsr_r);
      data_n    = make_pkt(sent_r + count_width_lp'(1), lfsr_step(tx_lfsr_r));
    end

    // Advance on every checked beat so one corrupt packet does not desync the rest.
    if (rx_check) begin
      recv_n    = recv_r + count_width_lp'(1);
      rx_lfsr_n = lfsr_step(rx_lfsr_r);
    end

    if (rx_bad) begin
      err_n = 1'b1;
      if (err_cnt_r != '1) err_cnt_n = err_cnt_r + count_width_lp'(1);
    end

    case (state_r)
      idle_s: begin
        if (en_i) begin
          state_n = run_s;
          data_n  = make_pkt(sent_r, tx_lfsr_r);
        end
      end
      run_s: begin
        if (tx_done && rx_done) state_n = done_s;
        else if (tx_done)       state_n = drain_s;
      end
      drain_s: begin
        if (rx_done) state_n = done_s;
      end
      done_s:  state_n = done_s;
      default: state_n = idle_s;
    endcase

`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
    // Watchdog on receive progress; expiry ends the run as failed.
    if (((state_r == run_s) || (state_r == drain_s)) && !yumi_c) begin
      wd_n = wd_r + wd_width_lp'(1);
      if (wd_r == wd_width_lp'(timeout_p - 1)) begin
        state_n   = done_s;
        err_n     = 1'b1;
        timeout_n = 1'b1;
      end
    end
`endif

    v_n    = (state_n == run_s);
    done_n = (state_n == done_s);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= idle_s;
      tx_lfsr_r <= seed_p;
      rx_lfsr_r <= seed_p;
      sent_r    <= '0;
      recv_r    <= '0;
      err_cnt_r <= '0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      v_r       <= 1'b0;
      data_r    <= '0;
`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
      wd_r      <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      tx_lfsr_r <= tx_lfsr_n;
      rx_lfsr_r <= rx_lfsr_n;
      sent_r    <= sent_n;
      recv_r    <= recv_n;
      err_cnt_r <= err_cnt_n;
      err_r     <= err_n;
      done_r    <= done_n;
      v_r       <= v_n;
      data_r    <= data_n;
`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
      wd_r      <= wd_n;
      timeout_r <= timeout_n;
`endif
    end
  end

  assign done_o        = done_r;
  assign error_o       = err_r;
  assign sent_count_o  = sent_r;
  assign recv_count_o  = recv_r;
  assign error_count_o = err_cnt_r;
`ifdef BSG_GATEWAY_LINK_TIMEOUT_EN
  assign timeout_o     = timeout_r;
`endif

endmodule

// File: doc/bsg_gateway_link_traffic_checker.md
Name: bsg_gateway_link_traffic_checker

Overview:
- Bring-up traffic generator/checker on the gateway chip's core (hb_clk) side.
- Drives one logical link's ready/valid inbound channel (the links_i side of the CT/FIFO link block) with a deterministic packet stream.
- Consumes the looped-back stream from the link block's outbound side and checks it packet by packet.
- Reports sent/received/error counts and done/error status, so link training can be confirmed before the core complex is released.

Parameters:
- width_p, 64, packet width in bits; must be >= 32.
- num_packets_p, 256, packets sent and expected per run; range 1..65535.
- seed_p, 32'h1, LFSR seed; must be nonzero.
- timeout_p, 1024, watchdog cycles without receive progress; used only with the optional feature.

Ports:
- clk_i, in, 1, core clock (hb_clk).
- reset_i, in, 1, asynchronous active-high reset.
- en_i, in, 1, start request (tag trace done, synchronized); sampled only in IDLE.
- v_o, out, 1, transmit packet valid.
- data_o, out, width_p, transmit packet.
- ready_i, in, 1, link block accepts packet.
- v_i, in, 1, received packet valid.
- data_i, in, width_p, received packet.
- yumi_o, out, 1, received packet consumed.
- done_o, out, 1, run complete (sticky).
- error_o, out, 1, any mismatch seen (sticky).
- sent_count_o, out, 16, packets sent.
- recv_count_o, out, 16, packets received.
- error_count_o, out, 16, mismatching packets, saturating at 16'hFFFF.

Behaviour:
- One clock, clk_i. reset_i is asynchronous and active-high.
- Every register clears on reset_i. Reset values: v_o=0, yumi_o=0, done_o=0, error_o=0, all counts 0, state IDLE, both LFSRs=seed_p.
- Reset asserted mid-run aborts the run immediately. No residual state survives; a new run needs en_i again.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advanced once per packet.
- Payload of packet k: bits [15:0] = k[15:0]; bits [width_p-1:16] = LFSR state k, replicated and truncated to width_p-16 bits.
- TX and RX each keep an independent LFSR copy, both seeded with seed_p.
- States:
  - IDLE: en_i=1 -> RUN. v_o is asserted from the first RUN cycle, i.e. one cycle after en_i is sampled.
  - RUN: v_o=1 while sent_count < num_packets_p. When sent_count reaches num_packets_p -> DRAIN.
  - DRAIN: v_o=0. When recv_count reaches num_packets_p -> DONE.
  - DONE: done_o=1, v_o=0. Held until reset. en_i is ignored outside IDLE.
- TX handshake:
  - Transfer occurs on v_o & ready_i; sent_count and the TX LFSR advance in that same cycle.
  - data_o and v_o are registered and held stable while v_o & ~ready_i.
  - v_o never depends combinationally on ready_i.
- RX handshake:
  - yumi_o = v_i & (state is RUN, DRAIN or DONE). This is combinational from v_i. No data is accepted in IDLE.
  - In RUN/DRAIN, each yumi compares data_i with the expected packet from the RX LFSR and recv_count. On mismatch: error_count+1 (saturating) and error_o set.
  - The RX LFSR and recv_count advance on every yumi, match or not, so the checker stays aligned after a corrupted packet.
  - In DONE, any yumi is an unexpected packet: error_count+1, error_o set, recv_count unchanged.
- TX and RX transfers in the same cycle are independent and both take effect.
- done_o rises the cycle after the final RX yumi.
- Counts are exposed directly from their registers.

Optional Feature:
- Macro: BSG_GATEWAY_LINK_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in RUN and DRAIN. It clears on every yumi_o and increments otherwise.
  - On reaching timeout_p it sets error_o, sets the error_count MSB-independent flag bit timeout_o (extra 1-bit output port), and forces the state to DONE.
- When undefined: no counter, no timeout_o port; a stalled link leaves the block in RUN or DRAIN indefinitely.

Test Plan:
- Loopback data_o->data_i, ready_i=1, num_packets_p=4, en_i pulse -> 4 transfers on consecutive cycles; done_o=1 one cycle after 4th yumi; counts 4/4/0; error_o=0.
- Loopback through a 2-entry FIFO with random ready_i (50%), num_packets_p=256 -> data_o stable under stall; done_o with counts 256/256/0.
- Flip bit 20 of packet 2 on the return path (num_packets_p=8) -> error_count=1, error_o=1; packets 3..7 match; done_o=1 with recv_count=8.
- After DONE, inject one extra v_i=1 beat -> yumi_o=1, error_count increments by 1, recv_count stays num_packets_p.
- Assert reset_i during RUN after 3 sends -> next edge all outputs 0, state IDLE; en_i reruns and packet 0 again carries LFSR=seed_p, seq=0.
- With BSG_GATEWAY_LINK_TIMEOUT_EN, timeout_p=16, v_i held 0 -> timeout_o=1, error_o=1, done_o=1 on the 16th idle cycle after entering RUN.
